sha256_block_padder: RTL and testbench

- Upstream feeder for the SHA-256 core. Accepts an arbitrary-length byte message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit bit-length.
- Emits complete 512-bit blocks (16 words) over a valid/ready handshake, with first/last-block flags. Core-side glue uses these flags to select the IV or the chaining value and to pulse the core's load.

---
 rtl/sha256_block_padder.sv | 159 +++++++++++++++
 tb/tb_sha256_block_padder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: packs a big-endian 32-bit word stream into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit message bit-length.
module sha256_block_padder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    input  logic [1:0]                 s_bytes,
    output logic                       s_ready,
    output logic [16*DATA_WIDTH-1:0]   m_block,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_first,
    output logic                       m_last
);

    localparam int unsigned NWORDS = 16;
    localparam int unsigned CW     = LEN_WIDTH - 3;

    typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             idx;
    logic [CW-1:0]          byte_cnt;
    logic                   pend80;
    logic                   pad_started;
    logic                   len_hi_done;
    logic [DATA_WIDTH-1:0]  words [NWORDS];
    logic                   s_ready_nxt, m_valid_nxt, m_last_nxt;
    logic                   accept, hs;
    logic [DATA_WIDTH-1:0]  last_word;
    logic [CW-1:0]          byte_inc;
    logic [LEN_WIDTH-1:0]   len;

    assign accept   = s_valid & s_ready;
    assign hs       = m_valid & m_ready;
    assign len      = {byte_cnt, 3'b000};
    assign byte_inc = (s_last && s_bytes != 2'd0) ? CW'(s_bytes) : CW'(4);

    // Final word: keep the valid bytes and place the 0x80 marker right after them.
    always_comb begin
        last_word = s_data;
        case (s_bytes)
            2'd1:    last_word = {s_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {s_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {s_data[31:8], 8'h80};
            default: last_word = s_data;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= s_ready_nxt;
            m_valid <= m_valid_nxt;
            m_last  <= m_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (idx == 4'd15)
                        state_nxt = EMIT;
                    else if (s_last)
                        state_nxt = PAD;
                end
            end
            PAD: begin
                if (idx == 4'd15)
                    state_nxt = EMIT;
            end
            EMIT: begin
                if (hs)
                    state_nxt = (!m_last && pad_started) ? PAD : FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Output logic; m_last is latched only when a block is entering EMIT
    always_comb begin
        s_ready_nxt = (state_nxt == FILL);
        m_valid_nxt = (state_nxt == EMIT);
        m_last_nxt  = m_last;
        if (state_nxt == EMIT && state != EMIT)
            m_last_nxt = (state == PAD) && len_hi_done && (idx == 4'd15);
    end

    // Block buffer, word index and length bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 4'd0;
            byte_cnt    <= '0;
            pend80      <= 1'b0;
            pad_started <= 1'b0;
            len_hi_done <= 1'b0;
            m_first     <= 1'b1;
            for (int i = 0; i < int'(NWORDS); i++)
                words[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        words[idx] <= s_last ? last_word : s_data;
                        byte_cnt   <= byte_cnt + byte_inc;
                        idx        <= idx + 4'd1;
                        if (s_last) begin
                            pad_started <= 1'b1;
                            pend80      <= (s_bytes == 2'd0);
                        end
                    end
                end
                PAD: begin
                    if (idx == 4'd14 && !pend80) begin
                        words[idx]  <= len[LEN_WIDTH-1 -: DATA_WIDTH];
                        len_hi_done <= 1'b1;
                    end else if (idx == 4'd15 && len_hi_done) begin
                        words[idx] <= len[DATA_WIDTH-1:0];
                    end else begin
                        words[idx] <= pend80 ? DATA_WIDTH'(32'h8000_0000) : '0;
                        pend80     <= 1'b0;
                    end
                    idx <= idx + 4'd1;
                end
                EMIT: begin
                    if (hs) begin
                        idx     <= 4'd0;
                        m_first <= m_last;
                        if (m_last) begin
                            byte_cnt    <= '0;
                            pad_started <= 1'b0;
                            len_hi_done <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < int'(NWORDS); gi++) begin : g_block
        assign m_block[(int'(NWORDS) - gi) * int'(DATA_WIDTH) - 1 -: DATA_WIDTH] = words[gi];
    end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench for sha256_block_padder: hand-computed padded blocks plus a
// byte-level reference padder for the data-bearing words.
module tb_sha256_block_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [1:0]   s_bytes;
    logic         s_ready;
    logic [511:0] m_block;
    logic         m_valid;
    logic         m_ready;
    logic         m_first;
    logic         m_last;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_q[$];
    logic [511:0] got;
    logic [511:0] exp_abc;
    int           cyc;

    always #5 clk = ~clk;

    sha256_block_padder dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_bytes (s_bytes),
        .s_ready (s_ready),
        .m_block (m_block),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_first (m_first),
        .m_last  (m_last)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void make_msg(input int n, input logic [7:0] base);
        msg.delete();
        for (int i = 0; i < n; i++)
            msg.push_back(8'(int'(base) + i));
    endfunction

    // Reference padding done on bytes, independent of the word-level datapath
    function automatic void build_ref();
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        exp_q.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56)
            p.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--)
            p.push_back(bitlen[8*i +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++)
                blk = {blk[503:0], p[64*b + i]};
            exp_q.push_back(blk);
        end
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] b);
        int t = 0;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 512'(s_ready), 512'(1));
            return;
        end
        s_data  = d;
        s_last  = l;
        s_bytes = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Bytes past the message end are filled with 0xEE so masking is exercised
    task automatic send_msg();
        int          nw;
        logic [31:0] w;
        logic [7:0]  bt;
        nw = (msg.size() + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                bt = (4*j + k < msg.size()) ? msg[4*j + k] : 8'hEE;
                w  = {w[23:0], bt};
            end
            send_word(w, (j == nw - 1), (j == nw - 1) ? 2'(msg.size() % 4) : 2'd0);
        end
    endtask

    task automatic recv_block(input string tag, input logic [511:0] exp,
                              input logic ef, input logic el, output logic [511:0] blk);
        int t = 0;
        @(negedge clk);
        while (!m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 512'(m_valid), 512'(1));
        check({tag, "_block"}, m_block, exp);
        check({tag, "_flags"}, 512'({m_first, m_last}), 512'({ef, el}));
        blk     = m_block;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, 512'(m_valid), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = 2'd0;
        m_ready = 1'b0;
        exp_abc = {32'h61626380, 448'h0, 32'h00000018};

        repeat (2) @(negedge clk);
        check("reset_ctrl", 512'({s_ready, m_valid, m_first, m_last}), 512'(4'b1010));
        check("reset_block", m_block, 512'h0);
        rst = 1'b0;

        // "abc": single block, latency from accept to m_valid
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg();
        cyc = 0;
        while (!m_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abc_latency", 512'(cyc), 512'(16));
        recv_block("abc", exp_abc, 1'b1, 1'b1, got);

        // One byte: 0x80 at byte 1
        msg = '{8'h5A};
        send_msg();
        recv_block("b1", {32'h5A800000, 448'h0, 32'h00000008}, 1'b1, 1'b1, got);

        // Six bytes: second word has two valid bytes
        make_msg(6, 8'hA0);
        send_msg();
        recv_block("b6", {32'hA0A1A2A3, 32'hA4A58000, 416'h0, 32'h00000030}, 1'b1, 1'b1, got);

        // 55 bytes: just fits in one block
        make_msg(55, 8'h01);
        build_ref();
        send_msg();
        recv_block("m55", exp_q[0], 1'b1, 1'b1, got);
        check("m55_w13", 512'(got[511-32*13 -: 32]), 512'(32'h35363780));
        check("m55_w14", 512'(got[511-32*14 -: 32]), 512'(32'h0));
        check("m55_w15", 512'(got[511-32*15 -: 32]), 512'(32'h000001B8));

        // 56 bytes: marker fits, length spills into a second block
        make_msg(56, 8'h40);
        build_ref();
        send_msg();
        recv_block("m56a", exp_q[0], 1'b1, 1'b0, got);
        check("m56a_w14", 512'(got[511-32*14 -: 32]), 512'(32'h80000000));
        check("m56a_w15", 512'(got[511-32*15 -: 32]), 512'(32'h0));
        recv_block("m56b", {480'h0, 32'h000001C0}, 1'b0, 1'b1, got);

        // 64 bytes with 20 cycles of backpressure on the data block
        make_msg(64, 8'h80);
        build_ref();
        send_msg();
        cyc = 0;
        while (!m_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        s_data  = 32'hDEADBEEF;
        s_last  = 1'b1;
        s_bytes = 2'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_ctrl", 512'({m_valid, s_ready, m_first, m_last}), 512'(4'b1010));
            check("bp_block", m_block, exp_q[0]);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        recv_block("m64a", exp_q[0], 1'b1, 1'b0, got);
        recv_block("m64b", {32'h80000000, 448'h0, 32'h00000200}, 1'b0, 1'b1, got);

        // Asynchronous reset in the middle of PAD, then a clean "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctrl", 512'({s_ready, m_valid, m_first, m_last}), 512'(4'b1010));
        check("arst_block", m_block, 512'h0);
        @(negedge clk);
        rst = 1'b0;
        send_msg();
        recv_block("abc2", exp_abc, 1'b1, 1'b1, got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
